// File: rtl/itype_alu_sequencer_if.sv
// Bus bundle for the I-type sequencer: instruction handshake, external ALU
// port, register write observability, error flags and debug read.
interface itype_alu_sequencer_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_rs;
  logic [31:0] alu_rt;
  logic [31:0] alu_imm;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carryout;
  logic [31:0] pc;
  logic        done;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ovf_err;
  logic        illegal_err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport slave (
    input  instr, instr_valid, alu_result, alu_zero, alu_overflow, alu_carryout, dbg_addr,
    output instr_ready, alu_opcode, alu_rs, alu_rt, alu_imm, pc, done,
           wb_en, wb_addr, wb_data, ovf_err, illegal_err, dbg_data
  );

  modport master (
    output instr, instr_valid, alu_result, alu_zero, alu_overflow, alu_carryout, dbg_addr,
    input  instr_ready, alu_opcode, alu_rs, alu_rt, alu_imm, pc, done,
           wb_en, wb_addr, wb_data, ovf_err, illegal_err, dbg_data
  );
endinterface

// File: rtl/itype_alu_sequencer.sv
// Four-phase I-type instruction sequencer driving an external combinational ALU,
// with a 32x32 register file, program counter and sticky error flags.
//
// state  | meaning
// IDLE   | ready for an instruction; latch it on valid
// DECODE | read rs/rt into operand latches, extend immediate
// EXEC   | present operands to the ALU, capture result and flags
// WB     | done pulse; register write and pc update on exit
module itype_alu_sequencer (
  input  logic                        clk,
  input  logic                        rst_n,
  itype_alu_sequencer_if.slave        bus
);

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] rs_q, rt_q, imm_q;
  logic [31:0] result_q;
  logic        zero_q, ovf_q;
  logic [31:0] pc_q;
  logic        ovf_err_q, illegal_err_q;
  logic [31:0] regs_q [32];

  logic [5:0]  opcode;
  logic [4:0]  rs_idx, rt_idx;
  logic [15:0] imm16;
  logic [31:0] imm_ext;
  logic        writes_rt, legal, taken, ovf_hit;
  logic        wb_en;

  assign opcode = instr_q[31:26];
  assign rs_idx = instr_q[25:21];
  assign rt_idx = instr_q[20:16];
  assign imm16  = instr_q[15:0];

  always_comb begin
    imm_ext = {{16{imm16[15]}}, imm16};
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_LUI) imm_ext = {16'h0000, imm16};
  end

  // Classification uses the flags captured in EXEC, so it is only meaningful in WB.
  always_comb begin
    writes_rt = 1'b0;
    legal     = 1'b1;
    taken     = 1'b0;
    ovf_hit   = 1'b0;
    case (opcode)
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI: writes_rt = 1'b1;
      OP_ADDI: begin
        writes_rt = !ovf_q;
        ovf_hit   = ovf_q;
      end
      OP_BEQ:  taken = zero_q;
      OP_BNE:  taken = !zero_q;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.instr_ready = 1'b0;
    bus.done        = 1'b0;
    bus.alu_opcode  = 6'd0;
    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        bus.alu_opcode = opcode;
        state_d        = WB;
      end
      WB: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb_en = (state_q == WB) && writes_rt && (rt_idx != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q       <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      imm_q         <= '0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      ovf_q         <= 1'b0;
      pc_q          <= '0;
      ovf_err_q     <= 1'b0;
      illegal_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.instr_valid) instr_q <= bus.instr;
        DECODE: begin
          rs_q  <= regs_q[rs_idx];
          rt_q  <= regs_q[rt_idx];
          imm_q <= imm_ext;
        end
        EXEC: begin
          result_q <= bus.alu_result;
          zero_q   <= bus.alu_zero;
          ovf_q    <= bus.alu_overflow;
        end
        WB: begin
          // imm_q already holds the sign-extended offset for branches.
          pc_q          <= pc_q + 32'd4 + (taken ? {imm_q[29:0], 2'b00} : 32'd0);
          ovf_err_q     <= ovf_err_q | ovf_hit;
          illegal_err_q <= illegal_err_q | !legal;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[rt_idx] <= result_q;
    end
  end

  assign bus.alu_rs      = rs_q;
  assign bus.alu_rt      = rt_q;
  assign bus.alu_imm     = imm_q;
  assign bus.pc          = pc_q;
  assign bus.wb_en       = wb_en;
  assign bus.wb_addr     = rt_idx;
  assign bus.wb_data     = result_q;
  assign bus.ovf_err     = ovf_err_q;
  assign bus.illegal_err = illegal_err_q;
  // Register 0 is never written, so a plain read returns 0 for it.
  assign bus.dbg_data    = regs_q[bus.dbg_addr];

endmodule

// File: tb/tb_itype_alu_sequencer.sv
// Self-checking bench for itype_alu_sequencer: behavioural ALU, reference
// model feeding a scoreboard queue, and per-scenario directed checks.
module tb_itype_alu_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  itype_alu_sequencer_if bus ();

  itype_alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        pc_chk_pending = 1'b0;
  exp_t        pc_chk;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_ovf, m_ill;
  logic [32:0] alu_sum;

  // Behavioural external ALU.
  always_comb begin
    alu_sum          = '0;
    bus.alu_result   = '0;
    bus.alu_overflow = 1'b0;
    bus.alu_carryout = 1'b0;
    case (bus.alu_opcode)
      6'h08, 6'h09: begin
        alu_sum          = {1'b0, bus.alu_rs} + {1'b0, bus.alu_imm};
        bus.alu_result   = alu_sum[31:0];
        bus.alu_carryout = alu_sum[32];
        bus.alu_overflow = (bus.alu_rs[31] == bus.alu_imm[31]) && (alu_sum[31] != bus.alu_rs[31]);
      end
      6'h0A: bus.alu_result = ($signed(bus.alu_rs) < $signed(bus.alu_imm)) ? 32'd1 : 32'd0;
      6'h0B: bus.alu_result = (bus.alu_rs < bus.alu_imm) ? 32'd1 : 32'd0;
      6'h0C: bus.alu_result = bus.alu_rs & bus.alu_imm;
      6'h0D: bus.alu_result = bus.alu_rs | bus.alu_imm;
      6'h0F: bus.alu_result = {bus.alu_imm[15:0], 16'h0000};
      6'h04, 6'h05: bus.alu_result = bus.alu_rs - bus.alu_rt;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc  = '0;
    m_ovf = 1'b0;
    m_ill = 1'b0;
    sbq.delete();
    pc_chk_pending = 1'b0;
  endtask

  task automatic model_push(input logic [31:0] ins);
    exp_t        e;
    logic [31:0] a, b, sx, zx, v;
    logic [4:0]  t;
    logic        wr, tk;
    a  = m_regs[ins[25:21]];
    t  = ins[20:16];
    b  = m_regs[t];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    wr = 1'b0;
    tk = 1'b0;
    v  = '0;
    case (ins[31:26])
      6'h08: begin
        v = a + sx;
        if (a[31] == sx[31] && v[31] != a[31]) m_ovf = 1'b1;
        else wr = 1'b1;
      end
      6'h09: begin v = a + sx; wr = 1'b1; end
      6'h0A: begin v = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; wr = 1'b1; end
      6'h0B: begin v = (a < sx) ? 32'd1 : 32'd0; wr = 1'b1; end
      6'h0C: begin v = a & zx; wr = 1'b1; end
      6'h0D: begin v = a | zx; wr = 1'b1; end
      6'h0F: begin v = {ins[15:0], 16'h0000}; wr = 1'b1; end
      6'h04: tk = (a == b);
      6'h05: tk = (a != b);
      default: m_ill = 1'b1;
    endcase
    e.wen   = wr && (t != 5'd0);
    e.waddr = t;
    e.wdata = v;
    if (e.wen) m_regs[t] = v;
    m_pc  = m_pc + 32'd4 + (tk ? {sx[29:0], 2'b00} : 32'd0);
    e.pc  = m_pc;
    e.ovf = m_ovf;
    e.ill = m_ill;
    sbq.push_back(e);
  endtask

  // Scoreboard monitor: pops on each done pulse, checks pc/flags the cycle after.
  always @(negedge clk) begin
    if (pc_chk_pending) begin
      pc_chk_pending = 1'b0;
      checks++;
      if (bus.pc !== pc_chk.pc || bus.ovf_err !== pc_chk.ovf || bus.illegal_err !== pc_chk.ill) begin
        errors++;
        $display("FAIL retire_state pc=%h ovf=%b ill=%b expected pc=%h ovf=%b ill=%b",
                 bus.pc, bus.ovf_err, bus.illegal_err, pc_chk.pc, pc_chk.ovf, pc_chk.ill);
      end
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done=1 expected no retirement");
      end else begin
        pc_chk = sbq.pop_front();
        pc_chk_pending = 1'b1;
        if (bus.wb_en !== pc_chk.wen) begin
          errors++;
          $display("FAIL wb_en got %b expected %b", bus.wb_en, pc_chk.wen);
        end else if (pc_chk.wen && (bus.wb_addr !== pc_chk.waddr || bus.wb_data !== pc_chk.wdata)) begin
          errors++;
          $display("FAIL wb_write got r%0d=%h expected r%0d=%h",
                   bus.wb_addr, bus.wb_data, pc_chk.waddr, pc_chk.wdata);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] ins);
    int n = 0;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.instr_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout instr_ready=%b expected 1", bus.instr_ready);
    end else begin
      bus.instr = ins;
      bus.instr_valid = 1'b1;
      model_push(ins);
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr = $urandom;
    end
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((sbq.size() != 0 || pc_chk_pending) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || pc_chk_pending) begin
      checks++;
      errors++;
      $display("FAIL retire_timeout pending=%0d expected 0", sbq.size());
      model_reset();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.pc !== 32'd0 || bus.done !== 1'b0 || bus.wb_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_pc_done pc=%h done=%b wb_en=%b expected 0 0 0", bus.pc, bus.done, bus.wb_en);
    end
    checks++;
    if (bus.ovf_err !== 1'b0 || bus.illegal_err !== 1'b0 || bus.alu_opcode !== 6'd0) begin
      errors++;
      $display("FAIL reset_flags ovf=%b ill=%b op=%h expected 0 0 0", bus.ovf_err, bus.illegal_err, bus.alu_opcode);
    end
    checks++;
    if (bus.alu_rs !== 32'd0 || bus.alu_rt !== 32'd0 || bus.alu_imm !== 32'd0) begin
      errors++;
      $display("FAIL reset_operands rs=%h rt=%h imm=%h expected 0", bus.alu_rs, bus.alu_rt, bus.alu_imm);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b expected 1", bus.instr_ready);
    end
  endtask

  task automatic test_addi();
    do_reset();
    bus.dbg_addr = 5'd1;
    send(enc(6'b001000, 5'd0, 5'd1, 16'hB4E9));
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.instr_ready !== 1'b0) begin
      errors++;
      $display("FAIL addi_decode done=%b ready=%b expected 0 0", bus.done, bus.instr_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.alu_opcode !== 6'b001000 || bus.alu_imm !== 32'hFFFFB4E9 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL addi_exec op=%h imm=%h done=%b expected 08 FFFFB4E9 0", bus.alu_opcode, bus.alu_imm, bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL addi_done_cycle4 got %b expected 1", bus.done);
    end
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 32'hFFFFB4E9 || bus.pc !== 32'd4 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL addi_result r1=%h pc=%h done=%b expected FFFFB4E9 4 0", bus.dbg_data, bus.pc, bus.done);
    end
    checks++;
    if (bus.alu_opcode !== 6'd0 || bus.alu_imm !== 32'hFFFFB4E9) begin
      errors++;
      $display("FAIL addi_idle_alu op=%h imm=%h expected 00 FFFFB4E9", bus.alu_opcode, bus.alu_imm);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send(enc(6'b001111, 5'd0, 5'd1, 16'h7FFF));
    send(enc(6'b001101, 5'd1, 5'd1, 16'hFFFF));
    send(enc(6'b001000, 5'd1, 5'd2, 16'h0001));
    wait_quiet();
    bus.dbg_addr = 5'd1;
    #1;
    checks++;
    if (bus.dbg_data !== 32'h7FFFFFFF || bus.ovf_err !== 1'b1 || bus.pc !== 32'd12) begin
      errors++;
      $display("FAIL ovf_seq r1=%h ovf=%b pc=%h expected 7FFFFFFF 1 C", bus.dbg_data, bus.ovf_err, bus.pc);
    end
    bus.dbg_addr = 5'd2;
    #1;
    checks++;
    if (bus.dbg_data !== 32'd0) begin
      errors++;
      $display("FAIL ovf_suppressed r2=%h expected 0", bus.dbg_data);
    end
    send(enc(6'b001001, 5'd0, 5'd2, 16'h0003));
    wait_quiet();
    checks++;
    if (bus.ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b expected 1", bus.ovf_err);
    end
  endtask

  task automatic test_slt();
    int n = 0;
    do_reset();
    bus.dbg_addr = 5'd3;
    send(enc(6'b001011, 5'd0, 5'd3, 16'hFFFF));
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < 8);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL sltiu_done_timeout done=%b expected 1", bus.done);
    end else if (bus.dbg_data !== 32'd0) begin
      errors++;
      $display("FAIL dbg_old_value r3=%h expected 0", bus.dbg_data);
    end
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 32'd1) begin
      errors++;
      $display("FAIL sltiu_r3 got %h expected 1", bus.dbg_data);
    end
    send(enc(6'b001010, 5'd0, 5'd4, 16'hFFFF));
    send(enc(6'b001100, 5'd0, 5'd0, 16'h14C1));
    send(enc(6'b001100, 5'd0, 5'd5, 16'h14C1));
    wait_quiet();
    bus.dbg_addr = 5'd4;
    #1;
    checks++;
    if (bus.dbg_data !== 32'd0 || bus.pc !== 32'h10) begin
      errors++;
      $display("FAIL slti_r4 r4=%h pc=%h expected 0 10", bus.dbg_data, bus.pc);
    end
  endtask

  task automatic test_branch();
    do_reset();
    send(enc(6'b000100, 5'd0, 5'd0, 16'h0004));
    wait_quiet();
    checks++;
    if (bus.pc !== 32'h14) begin
      errors++;
      $display("FAIL beq_taken pc=%h expected 14", bus.pc);
    end
    send(enc(6'b000101, 5'd0, 5'd0, 16'h0004));
    send(enc(6'b000000, 5'd1, 5'd2, 16'h1234));
    wait_quiet();
    checks++;
    if (bus.pc !== 32'h1C || bus.illegal_err !== 1'b1) begin
      errors++;
      $display("FAIL bne_illegal pc=%h ill=%b expected 1C 1", bus.pc, bus.illegal_err);
    end
    send(enc(6'b001001, 5'd0, 5'd6, 16'h0005));
    send(enc(6'b000101, 5'd6, 5'd0, 16'hFFFE));
    wait_quiet();
    checks++;
    if (bus.pc !== 32'h1C || bus.illegal_err !== 1'b1) begin
      errors++;
      $display("FAIL bne_backward pc=%h ill=%b expected 1C 1", bus.pc, bus.illegal_err);
    end
  endtask

  task automatic test_back_to_back();
    int          issued = 0;
    int          d0;
    logic [31:0] prog [3];
    prog[0] = enc(6'b001001, 5'd0, 5'd8, 16'h0007);
    prog[1] = enc(6'b001001, 5'd8, 5'd9, 16'h0003);
    prog[2] = enc(6'b001101, 5'd9, 5'd10, 16'h0100);
    d0 = done_cnt;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_ready !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d got %b expected %b", k, bus.instr_ready, ((k % 4) == 0));
      end
      if (bus.instr_ready === 1'b1 && issued < 3) begin
        bus.instr = prog[issued];
        bus.instr_valid = 1'b1;
        model_push(prog[issued]);
        issued++;
      end
    end
    bus.instr_valid = 1'b0;
    wait_quiet();
    bus.dbg_addr = 5'd10;
    #1;
    checks++;
    if (done_cnt - d0 != 3 || bus.dbg_data !== 32'h0000010A) begin
      errors++;
      $display("FAIL b2b_done done_pulses=%0d r10=%h expected 3 10A", done_cnt - d0, bus.dbg_data);
    end
  endtask

  task automatic test_reset_abort();
    int d0;
    d0 = done_cnt;
    bus.dbg_addr = 5'd7;
    send(enc(6'b001001, 5'd0, 5'd7, 16'h1234));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.alu_opcode !== 6'b001001 || bus.pc === 32'd0) begin
      errors++;
      $display("FAIL abort_exec op=%h pc=%h expected 09 nonzero", bus.alu_opcode, bus.pc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pc !== 32'd0 || bus.alu_opcode !== 6'd0 || bus.done !== 1'b0 || bus.alu_imm !== 32'd0) begin
      errors++;
      $display("FAIL abort_async pc=%h op=%h done=%b imm=%h expected 0", bus.pc, bus.alu_opcode, bus.done, bus.alu_imm);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt != d0 || bus.instr_ready !== 1'b1 || bus.pc !== 32'd0 || bus.dbg_data !== 32'd0) begin
      errors++;
      $display("FAIL abort_after dones=%0d ready=%b pc=%h r7=%h expected 0 1 0 0",
               done_cnt - d0, bus.instr_ready, bus.pc, bus.dbg_data);
    end
  endtask

  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.dbg_addr = '0;
    test_reset();
    test_addi();
    test_overflow();
    test_slt();
    test_branch();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached expected completion");
    $fatal(1);
  end

endmodule

// File: doc/itype_alu_sequencer.md
ITYPE_ALU_SEQUENCER -- requirements
Module: itype_alu_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 instr  input  32  I-type word: opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
REQ-004 instr_valid  input  1  instr is presented.
REQ-005 instr_ready  output  1  sequencer accepts instr this cycle.
REQ-006 alu_opcode  output  6  opcode driven to the external combinational ALU.
REQ-007 alu_rs, alu_rt, alu_imm  output  32 each  ALU operands; alu_imm is pre-extended.
REQ-008 alu_result  input  32  ALU result.
REQ-009 alu_zero, alu_overflow, alu_carryout  input  1 each  ALU flags.
REQ-010 pc  output  32  program counter.
REQ-011 done  output  1  one-cycle pulse when an instruction retires.
REQ-012 wb_en, wb_addr[4:0], wb_data[31:0]  output  register write port (observability).
REQ-013 ovf_err, illegal_err  output  1 each  sticky error flags.
REQ-014 dbg_addr  input  5; dbg_data  output  32  combinational register-file read.

Function
REQ-015 The block SHALL hold a 32x32 register file; register 0 SHALL read 0 and ignore writes.
REQ-016 FSM states SHALL be IDLE, DECODE, EXEC, WB; every instruction SHALL traverse all four in order.
REQ-017 instr_ready SHALL be 1 only in IDLE; instr_valid&&instr_ready at edge E0 latches instr and moves to DECODE.
REQ-018 DECODE SHALL read rs/rt into operand latches and build alu_imm; E1 -> EXEC.
REQ-019 EXEC SHALL drive alu_opcode/alu_rs/alu_rt/alu_imm from latches and capture result and flags at E2; E2 -> WB.
REQ-020 WB SHALL assert done for exactly one cycle, perform write/pc update at E3, and return to IDLE; throughput one instruction per 4 cycles.
REQ-021 Outside EXEC, alu_opcode SHALL be 0 and alu operands SHALL hold their last values.
REQ-022 Immediate extension: ADDI(001000), ADDIU(001001), SLTI(001010), SLTIU(001011), BEQ(000100), BNE(000101) sign-extend; ANDI(001100), ORI(001101), LUI(001111) zero-extend.
REQ-023 ADDIU/ANDI/ORI/LUI/SLTI/SLTIU SHALL write alu_result to rt; wb_en=1 in WB only when rt!=0.
REQ-024 ADDI with alu_overflow=1 SHALL suppress the write and set ovf_err; otherwise write as REQ-023.
REQ-025 BEQ taken iff alu_zero=1; BNE taken iff alu_zero=0; branches SHALL never write registers.
REQ-026 pc update in WB: taken branch -> pc+4+(sext(imm)<<2); otherwise pc+4; 32-bit wrap-around, no flag.
REQ-027 Any other opcode SHALL set illegal_err, write nothing, advance pc by 4.
REQ-028 instr changes while not in IDLE SHALL be ignored.
REQ-029 A WB write to register N and a dbg read of N in the same cycle SHALL return the old value.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, pc=0, all registers 0, done=0, wb_en=0, ovf_err=0, illegal_err=0, alu_opcode=0, operand outputs 0; instr_ready=1 after release.
REQ-031 Reset in any state SHALL abort the in-flight instruction with no register or pc side effect.
REQ-032 Error flags SHALL clear only by reset.

Verification
REQ-033 After reset, ADDI rt=1 rs=0 imm=0xB4E9 -> alu_imm=0xFFFFB4E9, done at 4th cycle, r1=0xFFFFB4E9, pc=4.
REQ-034 LUI r1 0x7FFF; ORI r1 r1 0xFFFF; ADDI r2 r1 1 -> r1=0x7FFFFFFF, ovf_err=1, r2=0, pc=12.
REQ-035 SLTIU r3 r0 0xFFFF -> r3=1; SLTI r4 r0 0xFFFF -> r4=0; ANDI r5 r0 0x14C1 with rt=0 variant -> wb_en=0.
REQ-036 At pc=0: BEQ r0 r0 imm=4 -> pc=0x14; then BNE r0 r0 imm=4 -> pc=0x18; opcode 000000 -> illegal_err=1, pc=0x1C.
REQ-037 Accept instr, drop rst_n during EXEC -> pc=0, target reg 0, done never pulses, instr_ready=1 after release.
REQ-038 Hold instr_valid=1 continuously for 3 instructions -> instr_ready pulses every 4th cycle, exactly 3 done pulses.
